// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage scheduler.
// Bit-reversal is only consumed when FFT_SCHED_BITREV_EN is defined.
package fft_pkg;

  localparam int ADDR_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // One slot of the read-to-write delay line; addresses are zero-extended.
  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [ADDR_MAX_W-1:0] addr_n;
    logic [ADDR_MAX_W-1:0] addr_m;
  } dl_entry_t;

  function automatic logic [ADDR_MAX_W-1:0] bitrev(input logic [ADDR_MAX_W-1:0] addr,
                                                   input int log2n);
    logic [ADDR_MAX_W-1:0] full_rev;
    full_rev = {<<{addr}};
    return full_rev >> (ADDR_MAX_W - log2n);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly pair and twiddle index generator for in-place radix-2 DIT.
// Purely combinational; no configuration macros.
module fft_addr_gen #(
  parameter int LOG2N = 3,
  parameter int S_W   = $clog2(LOG2N)
) (
  input  logic [S_W-1:0]   stage_i,
  input  logic [LOG2N-2:0] b_i,
  output logic [LOG2N-1:0] addr_n_o,
  output logic [LOG2N-1:0] addr_m_o,
  output logic [LOG2N-2:0] tw_o
);

  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] n_addr;

  always_comb begin
    b_ext    = {1'b0, b_i};
    span     = LOG2N'(1) << stage_i;
    pos      = b_ext & (span - LOG2N'(1));
    grp      = b_ext >> stage_i;
    n_addr   = ((grp << stage_i) << 1) | pos;
    addr_n_o = n_addr;
    addr_m_o = n_addr + span;
    // pos < span, so the shifted index always fits in LOG2N-1 bits
    tw_o     = (LOG2N-1)'(pos << (LOG2N - 1 - int'(stage_i)));
  end

endmodule

// File: rtl/fft_stage_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with inter-stage drain.
// Define FFT_SCHED_BITREV_EN to bit-reverse final-stage write addresses.
module fft_stage_sched
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2N      = 3,
  parameter int RD_LAT     = 1,
  parameter int BF_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [LOG2N-1:0]      rd_addr_n,
  output logic [LOG2N-1:0]      rd_addr_m,
  output logic [LOG2N-2:0]      tw_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_n,
  input  logic [DATA_WIDTH-1:0] rd_data_m,
  input  logic [DATA_WIDTH-1:0] tw_data,
  output logic [DATA_WIDTH-1:0] x_N,
  output logic [DATA_WIDTH-1:0] x_M,
  output logic [DATA_WIDTH-1:0] w_N,
  input  logic [DATA_WIDTH-1:0] y_N,
  input  logic [DATA_WIDTH-1:0] y_M,
  output logic                  wr_en,
  output logic [LOG2N-1:0]      wr_addr_n,
  output logic [LOG2N-1:0]      wr_addr_m,
  output logic [DATA_WIDTH-1:0] wr_data_n,
  output logic [DATA_WIDTH-1:0] wr_data_m,
  output logic                  wr_last
);

  localparam int HALF     = (1 << LOG2N) / 2;
  localparam int DL_DEPTH = RD_LAT + BF_LAT;
  localparam int S_W      = $clog2(LOG2N);
  localparam int B_W      = LOG2N - 1;
  localparam int CNT_W    = $clog2(DL_DEPTH + 1);

  localparam logic [B_W-1:0]   B_LAST   = B_W'(HALF - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(LOG2N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DL_DEPTH - 1);

  sched_state_t     state_q, state_d;
  logic [S_W-1:0]   stage_q, stage_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rd_en_q, rd_last_q;
  logic [LOG2N-1:0] rd_addr_n_q, rd_addr_m_q;
  logic [LOG2N-2:0] tw_addr_q;

  logic [LOG2N-1:0] gen_addr_n, gen_addr_m;
  logic [LOG2N-2:0] gen_tw;

  dl_entry_t dl_q [DL_DEPTH];
  dl_entry_t dl_in, dl_out;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          stage_d = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (b_q == B_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          b_d = b_q + B_W'(1);
        end
      end
      DRAIN: begin
        // Drain length equals the read-to-write latency, so the last write
        // of this stage lands before the next stage's first read.
        if (cnt_q == CNT_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + S_W'(1);
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are computed from next-state so they register with the state update.
  fft_addr_gen #(
    .LOG2N (LOG2N),
    .S_W   (S_W)
  ) u_addr_gen (
    .stage_i  (stage_d),
    .b_i      (b_d),
    .addr_n_o (gen_addr_n),
    .addr_m_o (gen_addr_m),
    .tw_o     (gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_addr_n_q <= '0;
      rd_addr_m_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= (state_d == RUN);
      rd_last_q <= (state_d == RUN) && (stage_d == S_LAST);
      if (state_d == RUN) begin
        rd_addr_n_q <= gen_addr_n;
        rd_addr_m_q <= gen_addr_m;
        tw_addr_q   <= gen_tw;
      end
    end
  end

  always_comb begin
    dl_in        = '0;
    dl_in.valid  = rd_en_q;
    dl_in.last   = rd_last_q;
    dl_in.addr_n = ADDR_MAX_W'(rd_addr_n_q);
    dl_in.addr_m = ADDR_MAX_W'(rd_addr_m_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= dl_in;
      for (int i = 1; i < DL_DEPTH; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign dl_out = dl_q[DL_DEPTH-1];

  logic [ADDR_MAX_W-1:0] wr_n_full, wr_m_full;
`ifdef FFT_SCHED_BITREV_EN
  assign wr_n_full = dl_out.last ? bitrev(dl_out.addr_n, LOG2N) : dl_out.addr_n;
  assign wr_m_full = dl_out.last ? bitrev(dl_out.addr_m, LOG2N) : dl_out.addr_m;
`else
  assign wr_n_full = dl_out.addr_n;
  assign wr_m_full = dl_out.addr_m;
`endif

  logic unused_hi;
  assign unused_hi = ^{wr_n_full[ADDR_MAX_W-1:LOG2N], wr_m_full[ADDR_MAX_W-1:LOG2N]};

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rd_en     = rd_en_q;
  assign rd_addr_n = rd_addr_n_q;
  assign rd_addr_m = rd_addr_m_q;
  assign tw_addr   = tw_addr_q;

  assign x_N = rd_data_n;
  assign x_M = rd_data_m;
  assign w_N = tw_data;

  assign wr_en     = dl_out.valid;
  assign wr_last   = dl_out.last;
  assign wr_addr_n = wr_n_full[LOG2N-1:0];
  assign wr_addr_m = wr_m_full[LOG2N-1:0];
  assign wr_data_n = y_N;
  assign wr_data_m = y_M;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Bench for fft_stage_sched: timing table plus read/write scoreboard.
// Honours FFT_SCHED_BITREV_EN for final-stage write address expectations.
module tb_fft_stage_sched;

  localparam int DW        = 16;
  localparam int LOG2N     = 3;
  localparam int HALF      = 4;
  localparam int LAT       = 3;
  localparam int STAGE_CYC = HALF + LAT;
`ifdef FFT_SCHED_BITREV_EN
  localparam bit BREV = 1'b1;
`else
  localparam bit BREV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, rd_en, wr_en, wr_last;
  logic [2:0]    rd_addr_n, rd_addr_m, wr_addr_n, wr_addr_m;
  logic [1:0]    tw_addr;
  logic [DW-1:0] rd_data_n, rd_data_m, tw_data, x_N, x_M, w_N, y_N, y_M;
  logic [DW-1:0] wr_data_n, wr_data_m;

  fft_stage_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_n(rd_addr_n), .rd_addr_m(rd_addr_m), .tw_addr(tw_addr),
    .rd_data_n(rd_data_n), .rd_data_m(rd_data_m), .tw_data(tw_data),
    .x_N(x_N), .x_M(x_M), .w_N(w_N), .y_N(y_N), .y_M(y_M),
    .wr_en(wr_en), .wr_addr_n(wr_addr_n), .wr_addr_m(wr_addr_m),
    .wr_data_n(wr_data_n), .wr_data_m(wr_data_m), .wr_last(wr_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [2:0] brev(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  typedef struct {
    int         cyc;
    logic [2:0] n;
    logic [2:0] m;
    logic [1:0] tw;
    logic       last;
  } acc_t;

  acc_t rdq[$];
  acc_t wrq[$];
  acc_t er, ew;

  // Expected read sequence for one transform started in cycle t0.
  task automatic push_run(input int t0);
    acc_t e;
    for (int s = 0; s < LOG2N; s++) begin
      for (int b = 0; b < HALF; b++) begin
        int span, grp, pos;
        span   = 1 << s;
        grp    = b / span;
        pos    = b % span;
        e.n    = 3'(grp * 2 * span + pos);
        e.m    = 3'(grp * 2 * span + pos + span);
        e.tw   = 2'(pos * (HALF / span));
        e.last = (s == LOG2N - 1);
        e.cyc  = t0 + 1 + s * STAGE_CYC + b;
        rdq.push_back(e);
      end
    end
  endtask

  int done_cnt      = 0;
  int last_done_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      rdq.delete();
      wrq.delete();
    end else begin
      if (rd_en) begin
        if (rdq.size() == 0) begin
          chk("unexpected_rd_en", 1, 0);
        end else begin
          er = rdq.pop_front();
          chk("rd_cycle", cyc, er.cyc);
          chk("rd_addr_n", int'(rd_addr_n), int'(er.n));
          chk("rd_addr_m", int'(rd_addr_m), int'(er.m));
          chk("tw_addr", int'(tw_addr), int'(er.tw));
          ew     = er;
          ew.cyc = er.cyc + LAT;
          wrq.push_back(ew);
        end
        chk("fwd_x_N", int'(x_N), int'(rd_data_n));
        chk("fwd_x_M", int'(x_M), int'(rd_data_m));
        chk("fwd_w_N", int'(w_N), int'(tw_data));
      end
      if (wr_en) begin
        if (wrq.size() == 0) begin
          chk("unexpected_wr_en", 1, 0);
        end else begin
          ew = wrq.pop_front();
          chk("wr_cycle", cyc, ew.cyc);
          chk("wr_addr_n", int'(wr_addr_n), int'((BREV && ew.last) ? brev(ew.n) : ew.n));
          chk("wr_addr_m", int'(wr_addr_m), int'((BREV && ew.last) ? brev(ew.m) : ew.m));
          chk("wr_last", int'(wr_last), int'(ew.last));
          chk("wr_data_n", int'(wr_data_n), int'(y_N));
          chk("wr_data_m", int'(wr_data_m), int'(y_M));
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  // RAM/ROM and butterfly stand-ins: fresh data each cycle.
  initial begin
    rd_data_n = '0; rd_data_m = '0; tw_data = '0; y_N = '0; y_M = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_data_n = 16'($urandom);
      rd_data_m = 16'($urandom);
      tw_data   = 16'($urandom);
      y_N       = 16'h1234 + 16'(cyc);
      y_M       = 16'($urandom);
    end
  end

  typedef struct {
    int rel, rd, n, m, tw, wr, wn, wm, wl, busy, done;
  } vec_t;
  localparam int NV = 15;
  vec_t tab[NV];

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_addr_n"}, int'(rd_addr_n), 0);
    chk({tag, "_rd_addr_m"}, int'(rd_addr_m), 0);
    chk({tag, "_tw_addr"}, int'(tw_addr), 0);
    chk({tag, "_wr_addr_n"}, int'(wr_addr_n), 0);
    chk({tag, "_wr_last"}, int'(wr_last), 0);
  endtask

  int t0, t1, d0, idx;
  vec_t v;
  logic [2:0] wn3, wm3;

  initial begin
    //           rel rd n  m  tw wr wn wm wl busy done
    tab[0]  = '{ 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab[1]  = '{ 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    tab[2]  = '{ 2, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0};
    tab[3]  = '{ 3, 1, 4, 5, 0, 0, 0, 0, 0, 1, 0};
    tab[4]  = '{ 4, 1, 6, 7, 0, 1, 0, 1, 0, 1, 0};
    tab[5]  = '{ 5, 0, 0, 0, 0, 1, 2, 3, 0, 1, 0};
    tab[6]  = '{ 7, 0, 0, 0, 0, 1, 6, 7, 0, 1, 0};
    tab[7]  = '{ 8, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0};
    tab[8]  = '{ 9, 1, 1, 3, 2, 0, 0, 0, 0, 1, 0};
    tab[9]  = '{18, 1, 3, 7, 3, 1, 0, 4, 1, 1, 0};
    tab[10] = '{19, 0, 0, 0, 0, 1, 1, 5, 1, 1, 0};
    tab[11] = '{21, 0, 0, 0, 0, 1, 3, 7, 1, 1, 0};
    tab[12] = '{22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tab[13] = '{23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab[14] = '{24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal transform against the timing table.
    start = 1'b1;
    t0    = cyc;
    push_run(t0);
    idx   = 0;
    for (int rel = 0; rel <= 24; rel++) begin
      @(negedge clk);
      if (idx < NV && tab[idx].rel == rel) begin
        v = tab[idx];
        chk($sformatf("t%0d_rd_en", rel), int'(rd_en), v.rd);
        if (v.rd != 0) begin
          chk($sformatf("t%0d_rd_addr_n", rel), int'(rd_addr_n), v.n);
          chk($sformatf("t%0d_rd_addr_m", rel), int'(rd_addr_m), v.m);
          chk($sformatf("t%0d_tw_addr", rel), int'(tw_addr), v.tw);
        end
        chk($sformatf("t%0d_wr_en", rel), int'(wr_en), v.wr);
        if (v.wr != 0) begin
          wn3 = 3'(v.wn);
          wm3 = 3'(v.wm);
          if (BREV && v.wl != 0) begin
            wn3 = brev(wn3);
            wm3 = brev(wm3);
          end
          chk($sformatf("t%0d_wr_addr_n", rel), int'(wr_addr_n), int'(wn3));
          chk($sformatf("t%0d_wr_addr_m", rel), int'(wr_addr_m), int'(wm3));
          chk($sformatf("t%0d_wr_last", rel), int'(wr_last), v.wl);
          chk($sformatf("t%0d_wr_data_n", rel), int'(wr_data_n), int'(16'h1234 + 16'(cyc)));
        end
        chk($sformatf("t%0d_busy", rel), int'(busy), v.busy);
        chk($sformatf("t%0d_done", rel), int'(done), v.done);
        idx++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("s1_done_cycle", last_done_cyc, t0 + 22);
    chk("s1_done_count", done_cnt, 1);
    chk("s1_queues_empty", rdq.size() + wrq.size(), 0);

    // start while busy and in the DONE cycle must be ignored.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    t0    = cyc;
    d0    = done_cnt;
    push_run(t0);
    for (int rel = 0; rel < 36; rel++) begin
      @(posedge clk); #1;
      start = ((rel + 1) == 10) || ((rel + 1) == 22);
    end
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_done_cycle", last_done_cyc, t0 + 22);
    chk("ign_queues_empty", rdq.size() + wrq.size(), 0);
    chk("ign_busy_after", int'(busy), 0);

    // Reset mid-transform, then a fresh start.
    start = 1'b1;
    t0    = cyc;
    d0    = done_cnt;
    push_run(t0);
    for (int rel = 0; rel < 12; rel++) begin
      @(negedge clk);
      if (rel == 9 || rel == 10) check_zero($sformatf("midrst_t%0d", rel));
      @(posedge clk); #1;
      start = 1'b0;
      if ((rel + 1) == 9)  rst_n = 1'b0;
      if ((rel + 1) == 11) rst_n = 1'b1;
    end
    chk("midrst_no_done", done_cnt - d0, 0);
    start = 1'b1;
    t1    = cyc;
    push_run(t1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 60 && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_done_count", done_cnt - d0, 1);
    chk("restart_done_cycle", last_done_cyc, t1 + 22);
    chk("restart_queues_empty", rdq.size() + wrq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
